// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: rebuilds pixel coordinates, display-area flag and lock status from received h_sync/v_sync.
// Define VGA_SYNC_RX_WATCHDOG_EN to add a dead-input timeout on the line and frame counters.
module vga_sync_receiver #(
    parameter int H_TOTAL           = 800,
    parameter int H_SYNC            = 96,
    parameter int H_BACK            = 48,
    parameter int H_ACTIVE          = 640,
    parameter int V_TOTAL           = 525,
    parameter int V_SYNC            = 2,
    parameter int V_BACK            = 33,
    parameter int V_ACTIVE          = 480,
    parameter int LOCK_FRAMES       = 2,
    parameter int PIXEL_DISPLAY_BIT = 10
) (
    input  logic                         clock_25,
    input  logic                         reset,
    input  logic                         h_sync,
    input  logic                         v_sync,
    output logic [PIXEL_DISPLAY_BIT-1:0] rx_x,
    output logic [PIXEL_DISPLAY_BIT-1:0] rx_y,
    output logic                         rx_display_area,
    output logic                         locked,
    output logic                         frame_tik,
    output logic [7:0]                   err_count
);

    localparam int GW = $clog2(LOCK_FRAMES + 1);

    localparam logic [10:0]   LP_H_TOTAL   = 11'(H_TOTAL);
    localparam logic [10:0]   LP_V_TOTAL   = 11'(V_TOTAL);
    localparam logic [10:0]   LP_H_SYNC_M1 = 11'(H_SYNC - 1);
    localparam logic [10:0]   LP_H_START   = 11'(H_SYNC + H_BACK);
    localparam logic [10:0]   LP_H_END     = 11'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [10:0]   LP_V_START   = 11'(V_SYNC + V_BACK);
    localparam logic [10:0]   LP_V_END     = 11'(V_SYNC + V_BACK + V_ACTIVE - 1);
    localparam logic [GW-1:0] LP_LOCK      = GW'(LOCK_FRAMES);

`ifdef VGA_SYNC_RX_WATCHDOG_EN
    localparam logic [10:0]   LP_H_LIMIT   = 11'(2 * H_TOTAL);
    localparam logic [10:0]   LP_V_LIMIT   = 11'(2 * V_TOTAL);
`else
    localparam logic [10:0]   LP_H_LIMIT   = 11'h7FF;
    localparam logic [10:0]   LP_V_LIMIT   = 11'h7FF;
`endif

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_TRAIN  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        if (value == 8'hFF) begin
            sat_inc8 = value;
        end else begin
            sat_inc8 = value + 8'd1;
        end
    endfunction

    logic                         r_hs_q;
    logic                         r_hs_d;
    logic                         r_vs_q;
    logic                         r_vs_d;
    logic [10:0]                  r_h_cnt;
    logic [10:0]                  r_v_cnt;
    logic                         r_vpend;
    logic                         r_first_line;
    logic                         r_first_frame;
    logic                         r_frame_err;
    logic                         r_bound;
    state_t                       r_state;
    logic [GW-1:0]                r_good_cnt;
    logic [7:0]                   r_err_count;
    logic [PIXEL_DISPLAY_BIT-1:0] r_rx_x;
    logic [PIXEL_DISPLAY_BIT-1:0] r_rx_y;
    logic                         r_display_area;
    logic                         r_locked;
    logic                         r_frame_tik;

    logic                         w_hfall;
    logic                         w_hrise;
    logic                         w_vfall;
    logic                         w_vbound;
    logic                         w_line_err;
    logic                         w_pulse_err;
    logic                         w_frame_err;
    logic                         w_h_wd;
    logic                         w_v_wd;
    logic                         w_err_evt;
    logic [10:0]                  w_h_cnt_next;
    logic [10:0]                  w_v_cnt_next;
    state_t                       w_state_next;
    logic [GW-1:0]                w_good_next;
    logic                         w_out_en;
    logic                         w_h_in;
    logic                         w_v_in;
    logic                         w_da_next;
    logic [PIXEL_DISPLAY_BIT-1:0] w_x_next;
    logic [PIXEL_DISPLAY_BIT-1:0] w_y_next;
    logic                         w_tik_next;

    // Pin capture: _q is the sampled pin, _d its delayed copy for edge detection
    always_ff @(posedge clock_25) begin
        if (reset) begin
            r_hs_q <= 1'b1;
            r_hs_d <= 1'b1;
            r_vs_q <= 1'b1;
            r_vs_d <= 1'b1;
        end else begin
            r_hs_q <= h_sync;
            r_hs_d <= r_hs_q;
            r_vs_q <= v_sync;
            r_vs_d <= r_vs_q;
        end
    end

    assign w_hfall  = r_hs_d & ~r_hs_q;
    assign w_hrise  = ~r_hs_d & r_hs_q;
    assign w_vfall  = r_vs_d & ~r_vs_q;
    assign w_vbound = w_hfall & (r_vpend | w_vfall);

    assign w_line_err  = w_hfall & ~r_first_line & ((r_h_cnt + 11'd1) != LP_H_TOTAL);
    assign w_pulse_err = w_hrise & (r_h_cnt != LP_H_SYNC_M1);
    assign w_frame_err = w_vbound & ~r_first_frame & ((r_v_cnt + 11'd1) != LP_V_TOTAL);

`ifdef VGA_SYNC_RX_WATCHDOG_EN
    assign w_h_wd = ~w_hfall & (r_h_cnt == LP_H_LIMIT);
    assign w_v_wd = ~w_vbound & (r_v_cnt == LP_V_LIMIT);
`else
    assign w_h_wd = 1'b0;
    assign w_v_wd = 1'b0;
`endif

    // Several simultaneous errors form a single event; SEARCH ignores them all
    assign w_err_evt = (w_line_err | w_pulse_err | w_frame_err | w_h_wd | w_v_wd)
                     & (r_state != ST_SEARCH);

    // Line/frame counter next values; both hold at their limit instead of wrapping
    always_comb begin
        w_h_cnt_next = r_h_cnt;
        w_v_cnt_next = r_v_cnt;
        if (w_hfall) begin
            w_h_cnt_next = 11'd0;
        end else if (r_h_cnt != LP_H_LIMIT) begin
            w_h_cnt_next = r_h_cnt + 11'd1;
        end else begin
            w_h_cnt_next = r_h_cnt;
        end
        if (w_vbound) begin
            w_v_cnt_next = 11'd0;
        end else if (w_hfall && (r_v_cnt != LP_V_LIMIT)) begin
            w_v_cnt_next = r_v_cnt + 11'd1;
        end else begin
            w_v_cnt_next = r_v_cnt;
        end
    end

    // Counters and per-frame bookkeeping (pending vsync, skip flags, error-in-frame)
    always_ff @(posedge clock_25) begin
        if (reset) begin
            r_h_cnt       <= 11'd0;
            r_v_cnt       <= 11'd0;
            r_vpend       <= 1'b0;
            r_first_line  <= 1'b1;
            r_first_frame <= 1'b1;
            r_frame_err   <= 1'b0;
            r_bound       <= 1'b0;
        end else begin
            r_h_cnt <= w_h_cnt_next;
            r_v_cnt <= w_v_cnt_next;
            r_bound <= w_vbound;
            if (w_vbound) begin
                r_vpend <= 1'b0;
            end else if (w_vfall) begin
                r_vpend <= 1'b1;
            end else begin
                r_vpend <= r_vpend;
            end
            if (r_state == ST_SEARCH) begin
                r_first_line  <= 1'b1;
                r_first_frame <= 1'b1;
                r_frame_err   <= 1'b0;
            end else begin
                r_first_line  <= r_first_line & ~w_hfall;
                r_first_frame <= r_first_frame & ~w_vbound;
                if (w_vbound) begin
                    r_frame_err <= 1'b0;
                end else begin
                    r_frame_err <= r_frame_err | w_err_evt;
                end
            end
        end
    end

    // Lock FSM state register
    always_ff @(posedge clock_25) begin
        if (reset) begin
            r_state    <= ST_SEARCH;
            r_good_cnt <= {GW{1'b0}};
        end else begin
            r_state    <= w_state_next;
            r_good_cnt <= w_good_next;
        end
    end

    // Lock FSM next state: a frame is good only if no error hit it, including at its boundary
    always_comb begin
        w_state_next = r_state;
        w_good_next  = r_good_cnt;
        case (r_state)
            ST_SEARCH: begin
                if (w_vbound) begin
                    w_state_next = ST_TRAIN;
                    w_good_next  = {GW{1'b0}};
                end else begin
                    w_state_next = ST_SEARCH;
                end
            end
            ST_TRAIN: begin
                if (w_vbound) begin
                    if (r_frame_err || w_err_evt) begin
                        w_good_next = {GW{1'b0}};
                    end else if ((r_good_cnt + {{(GW-1){1'b0}}, 1'b1}) == LP_LOCK) begin
                        w_good_next  = r_good_cnt + {{(GW-1){1'b0}}, 1'b1};
                        w_state_next = ST_LOCKED;
                    end else begin
                        w_good_next = r_good_cnt + {{(GW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    w_state_next = ST_TRAIN;
                end
            end
            ST_LOCKED: begin
                if (w_err_evt) begin
                    w_state_next = ST_SEARCH;
                end else begin
                    w_state_next = ST_LOCKED;
                end
            end
            default: begin
                w_state_next = ST_SEARCH;
                w_good_next  = {GW{1'b0}};
            end
        endcase
    end

    // Output decode; gating on the next state drops everything the cycle after an error
    always_comb begin
        w_out_en   = (r_state == ST_LOCKED) && (w_state_next == ST_LOCKED);
        w_h_in     = (r_h_cnt >= LP_H_START) && (r_h_cnt <= LP_H_END);
        w_v_in     = (r_v_cnt >= LP_V_START) && (r_v_cnt <= LP_V_END);
        w_da_next  = w_out_en && w_h_in && w_v_in;
        w_tik_next = w_out_en && r_bound;
        w_x_next   = {PIXEL_DISPLAY_BIT{1'b0}};
        w_y_next   = {PIXEL_DISPLAY_BIT{1'b0}};
        if (w_da_next) begin
            w_x_next = PIXEL_DISPLAY_BIT'(r_h_cnt - LP_H_START);
            w_y_next = PIXEL_DISPLAY_BIT'(r_v_cnt - LP_V_START);
        end else begin
            w_x_next = {PIXEL_DISPLAY_BIT{1'b0}};
            w_y_next = {PIXEL_DISPLAY_BIT{1'b0}};
        end
    end

    // Output register stage and saturating error counter
    always_ff @(posedge clock_25) begin
        if (reset) begin
            r_rx_x         <= {PIXEL_DISPLAY_BIT{1'b0}};
            r_rx_y         <= {PIXEL_DISPLAY_BIT{1'b0}};
            r_display_area <= 1'b0;
            r_locked       <= 1'b0;
            r_frame_tik    <= 1'b0;
            r_err_count    <= 8'd0;
        end else begin
            r_rx_x         <= w_x_next;
            r_rx_y         <= w_y_next;
            r_display_area <= w_da_next;
            r_locked       <= w_out_en;
            r_frame_tik    <= w_tik_next;
            if (w_err_evt) begin
                r_err_count <= sat_inc8(r_err_count);
            end else begin
                r_err_count <= r_err_count;
            end
        end
    end

    assign rx_x            = r_rx_x;
    assign rx_y            = r_rx_y;
    assign rx_display_area = r_display_area;
    assign locked          = r_locked;
    assign frame_tik       = r_frame_tik;
    assign err_count       = r_err_count;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver on a scaled-down raster (20x10 clocks per frame).
module tb_vga_sync_receiver;

    localparam int HT = 20;
    localparam int HS = 3;
    localparam int HB = 2;
    localparam int HA = 12;
    localparam int VT = 10;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int VA = 5;
    localparam int PW = 10;

    logic          clock_25 = 1'b0;
    logic          reset    = 1'b1;
    logic          h_sync   = 1'b1;
    logic          v_sync   = 1'b1;
    logic [PW-1:0] rx_x;
    logic [PW-1:0] rx_y;
    logic          rx_display_area;
    logic          locked;
    logic          frame_tik;
    logic [7:0]    err_count;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    int g_f = 0, g_v = 0, g_h = 0;
    int g_len = HT, g_sw = HS;
    bit g_dead = 1'b0;
    int l_f = -1, l_v = -1, l_h = -1;

    vga_sync_receiver #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA),
        .LOCK_FRAMES(2), .PIXEL_DISPLAY_BIT(PW)
    ) dut (
        .clock_25(clock_25),
        .reset(reset),
        .h_sync(h_sync),
        .v_sync(v_sync),
        .rx_x(rx_x),
        .rx_y(rx_y),
        .rx_display_area(rx_display_area),
        .locked(locked),
        .frame_tik(frame_tik),
        .err_count(err_count)
    );

    always #20 clock_25 = ~clock_25;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One pixel clock: drive the raster pixel (g_h, g_v), wait past the edge, advance.
    task automatic tick();
        h_sync = ((g_h < g_sw) && !g_dead) ? 1'b0 : 1'b1;
        v_sync = (g_v < VS) ? 1'b0 : 1'b1;
        l_f = g_f;
        l_v = g_v;
        l_h = g_h;
        @(posedge clock_25);
        #1;
        g_h++;
        if (g_h >= g_len) begin
            g_h   = 0;
            g_len = HT;
            g_sw  = HS;
            if (g_v == VT - 1) begin
                g_v = 0;
                g_f++;
            end else begin
                g_v++;
            end
        end
    endtask

    task automatic goto_px(input int f, input int v, input int h);
        int n;
        n = 0;
        while (!(l_f == f && l_v == v && l_h == h) && n < 3000) begin
            tick();
            n++;
        end
        if (!(l_f == f && l_v == v && l_h == h)) begin
            n_chk++;
            n_fail++;
            $error("FAIL goto: observed f%0d v%0d h%0d expected f%0d v%0d h%0d", l_f, l_v, l_h, f, v, h);
        end
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clock_25);
        #1;
        chk("rst_x", 32'(rx_x), 0);
        chk("rst_y", 32'(rx_y), 0);
        chk("rst_da", 32'(rx_display_area), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_tik", 32'(frame_tik), 0);
        chk("rst_err", 32'(err_count), 0);
        reset = 1'b0;

        goto_px(1, 0, 2);
        chk("lock_after_b2", 32'(locked), 0);
        goto_px(2, 0, 1);
        chk("lock_b3_early", 32'(locked), 0);
        goto_px(2, 0, 2);
        chk("lock_b3", 32'(locked), 1);
        chk("tik_b3", 32'(frame_tik), 1);
        chk("err_clean", 32'(err_count), 0);
        goto_px(2, 0, 3);
        chk("tik_pulse_end", 32'(frame_tik), 0);

        goto_px(2, 4, 6);
        chk("da_before_first", 32'(rx_display_area), 0);
        goto_px(2, 4, 7);
        chk("da_first", 32'(rx_display_area), 1);
        chk("x_first", 32'(rx_x), 0);
        chk("y_first", 32'(rx_y), 0);
        goto_px(2, 8, 18);
        chk("da_last", 32'(rx_display_area), 1);
        chk("x_last", 32'(rx_x), 11);
        chk("y_last", 32'(rx_y), 4);
        goto_px(2, 8, 19);
        chk("da_after_last", 32'(rx_display_area), 0);
        chk("x_after_last", 32'(rx_x), 0);
        chk("y_after_last", 32'(rx_y), 0);

        goto_px(3, 4, 19);
        g_len = HT - 1;
        goto_px(3, 6, 0);
        chk("short_locked_hold", 32'(locked), 1);
        chk("short_err_hold", 32'(err_count), 0);
        goto_px(3, 6, 1);
        chk("short_locked_drop", 32'(locked), 0);
        chk("short_err", 32'(err_count), 1);
        chk("short_da", 32'(rx_display_area), 0);
        goto_px(5, 0, 2);
        chk("relock_early", 32'(locked), 0);
        goto_px(6, 0, 2);
        chk("relock", 32'(locked), 1);
        chk("relock_err", 32'(err_count), 1);

        goto_px(6, 6, 10);
        chk("mid_da", 32'(rx_display_area), 1);
        chk("mid_x", 32'(rx_x), 3);
        chk("mid_y", 32'(rx_y), 2);
        reset = 1'b1;
        tick();
        chk("mrst_x", 32'(rx_x), 0);
        chk("mrst_y", 32'(rx_y), 0);
        chk("mrst_da", 32'(rx_display_area), 0);
        chk("mrst_locked", 32'(locked), 0);
        chk("mrst_tik", 32'(frame_tik), 0);
        chk("mrst_err", 32'(err_count), 0);
        reset = 1'b0;

        goto_px(7, 2, 19);
        g_sw = HS - 1;
        goto_px(7, 3, 2);
        chk("pulse_err_before", 32'(err_count), 0);
        goto_px(7, 3, 3);
        chk("pulse_err", 32'(err_count), 1);
        goto_px(9, 0, 2);
        chk("train_delay", 32'(locked), 0);
        goto_px(10, 0, 2);
        chk("train_lock", 32'(locked), 1);
        chk("train_err", 32'(err_count), 1);

        goto_px(10, 2, 19);
        g_dead = 1'b1;
        goto_px(10, 5, 10);
        chk("dead_da", 32'(rx_display_area), 0);
`ifdef VGA_SYNC_RX_WATCHDOG_EN
        chk("dead_locked", 32'(locked), 0);
        chk("dead_err", 32'(err_count), 2);
`else
        chk("dead_locked", 32'(locked), 1);
        chk("dead_err", 32'(err_count), 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_sync_receiver.md
Name: vga_sync_receiver

Overview:
- Receive-side counterpart of the VGA timing generator. Consumes h_sync/v_sync, which are active-low 640x480@60 timing at one pixel per clock_25.
- Reconstructs pixel coordinates and the display-area flag, checks every line and frame against nominal timing, and reports lock status and error counts.
- Used as a loop-back checker on the VGA_HS/VGA_VS outputs, and as the timing front end for a future frame-capture path.

Parameters:
- H_TOTAL, 800, clocks per line
- H_SYNC, 96, hsync low width in clocks
- H_BACK, 48, back porch in clocks
- H_ACTIVE, 640, visible pixels per line
- V_TOTAL, 525, lines per frame
- V_SYNC, 2, vsync low width in lines
- V_BACK, 33, back porch in lines
- V_ACTIVE, 480, visible lines per frame
- LOCK_FRAMES, 2, consecutive clean frames needed to lock
- PIXEL_DISPLAY_BIT, 10, coordinate width

Ports:
- clock_25  in  1  pixel clock; the only clock
- reset  in  1  synchronous, active-high
- h_sync  in  1  received hsync, active low
- v_sync  in  1  received vsync, active low
- rx_x  out  PIXEL_DISPLAY_BIT  reconstructed column; 0 outside the active area
- rx_y  out  PIXEL_DISPLAY_BIT  reconstructed row; 0 outside the active area
- rx_display_area  out  1  high on active pixels while locked
- locked  out  1  timing lock achieved
- frame_tik  out  1  one-cycle pulse at each frame boundary while locked
- err_count  out  8  saturating count of error events

Behaviour:
- Reset: all outputs 0; state SEARCH; counters and edge registers 0. Sync input registers reset to 1 (idle).
- Input stage: h_sync and v_sync each pass through one register. Edge detection uses that register and its delayed copy.
- Line start (hfall): a 1->0 transition on registered h_sync. On hfall, h_cnt <= 0; otherwise h_cnt increments. h_cnt is 11 bits.
- Line check at hfall:
  - measured line length = h_cnt+1; it must equal H_TOTAL, else error.
  - This check is skipped on the first hfall after leaving SEARCH.
- Pulse check: on a registered h_sync rising edge, h_cnt must equal H_SYNC-1, else error.
- Frame start:
  - A registered v_sync falling edge sets vpend.
  - At the next hfall (including an hfall in the same cycle): v_cnt <= 0, vpend cleared, frame boundary declared.
  - Every other hfall increments v_cnt.
- Frame check: at a frame boundary the previous frame length (v_cnt+1) must equal V_TOTAL, else error. Skipped for the first boundary after SEARCH.
- State machine:
  - SEARCH -> TRAIN at the first frame boundary; good_cnt <= 0.
  - TRAIN, at each boundary: if the frame just ended had no error, good_cnt++; otherwise good_cnt <= 0. When good_cnt reaches LOCK_FRAMES -> LOCKED.
  - LOCKED: any error -> SEARCH.
  - Errors in SEARCH are ignored.
- Error events (TRAIN/LOCKED only):
  - err_count += 1 per cycle holding at least one error; several errors in the same cycle count once.
  - Saturates at 255; cleared only by reset.
- Output register stage, while LOCKED:
  - rx_display_area = (h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE-1]) && (v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE-1]).
  - When rx_display_area is high: rx_x = h_cnt-(H_SYNC+H_BACK), rx_y = v_cnt-(V_SYNC+V_BACK). Otherwise both are 0.
  - frame_tik = frame boundary.
  - When not LOCKED these outputs are forced to 0.
- Latency: 3 clocks from the h_sync pin edge to the corresponding registered output (input register, edge/counter, output register).
- Lock timing:
  - locked rises the cycle after entering LOCKED.
  - locked falls the cycle after the error cycle; rx_display_area drops in that same cycle.
- Reset asserted mid-frame returns the block to its reset state on the next edge. Re-lock then requires the full SEARCH/TRAIN sequence.

Optional Feature:
- Macro: VGA_SYNC_RX_WATCHDOG_EN.
- Defined:
  - h_cnt reaching 2*H_TOTAL without an hfall raises an error and h_cnt holds there.
  - Likewise, v_cnt reaching 2*V_TOTAL without a frame boundary raises an error and v_cnt holds.
  - Either case drops lock if LOCKED.
- Undefined:
  - No timeout. Counters saturate at all-ones silently.
  - A dead input leaves locked and its outputs frozen at their last values; rx_display_area goes low once h_cnt passes the active window.

Test Plan:
- Clean nominal 640x480 stream from reset -> locked rises after the 3rd frame boundary, 3 clocks after that boundary's hfall; err_count = 0.
- Locked stream, first active pixel (h_cnt=144, v_cnt=35) -> rx_display_area=1, rx_x=0, rx_y=0. Last active pixel -> rx_x=639, rx_y=479. The next pixel -> rx_display_area=0.
- Locked, one line shortened to 799 clocks -> err_count=1; locked=0 one cycle after the error; re-lock after a further 3 clean boundaries.
- TRAIN, hsync pulse 95 wide -> err_count increments, good_cnt restarts; locked delayed by one frame.
- Locked, reset pulsed for 1 cycle mid-frame -> all outputs 0 next cycle; err_count=0.
- Watchdog build, h_sync held high 1600 clocks while locked -> err_count=1, locked=0. Non-watchdog build: same stimulus -> locked stays 1.
